// File: rtl/writeback_stage.sv
// RAPID writeback stage: 2-entry skid buffer, load formatting/fault detection, register-file write port.
// Define RAPID_WB_RETIRE_CNT_EN to build the 64-bit retired-instruction counter; otherwise o_retired is 0.
module writeback_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_reg_write,
  input  logic              i_is_load,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_addr_lo,
  input  logic [XLEN-1:0]   i_result,
  input  logic [XLEN-1:0]   i_load_data,
  input  logic              i_hold,
  output logic              o_rf_we,
  output logic [REG_AW-1:0] o_rf_waddr,
  output logic [XLEN-1:0]   o_rf_wdata,
  output logic              o_fwd_valid,
  output logic [REG_AW-1:0] o_fwd_rd,
  output logic [XLEN-1:0]   o_fwd_data,
  output logic              o_load_fault,
  output logic [63:0]       o_retired
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
    logic [2:0]        funct3;
    logic [1:0]        addr_lo;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   load_data;
  } entry_t;

  entry_t            ent_q [2];
  entry_t            ent_d [2];
  logic [1:0]        count_q, count_d;
  logic              ready_q, ready_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              load_fault_q, load_fault_d;

  entry_t          head;
  entry_t          in_ent;
  logic            push;
  logic            pop;
  logic            head_illegal;
  logic            head_misaligned;
  logic            head_fault;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] head_data;

  assign in_ent = '{rd: i_rd, reg_write: i_reg_write, is_load: i_is_load, funct3: i_funct3,
                    addr_lo: i_addr_lo, result: i_result, load_data: i_load_data};
  assign head = ent_q[0];
  assign push = i_valid && ready_q;
  assign pop  = (count_q != 2'd0) && !i_hold;

  always_comb begin
    case (head.addr_lo)
      2'd0:    ld_byte = head.load_data[7:0];
      2'd1:    ld_byte = head.load_data[15:8];
      2'd2:    ld_byte = head.load_data[23:16];
      default: ld_byte = head.load_data[31:24];
    endcase
    ld_half = head.addr_lo[1] ? head.load_data[31:16] : head.load_data[15:0];

    head_illegal = head.is_load &&
                   ((head.funct3 == 3'b011) || (head.funct3 == 3'b110) || (head.funct3 == 3'b111));
    head_misaligned = head.is_load &&
                      ((((head.funct3 == 3'b001) || (head.funct3 == 3'b101)) && head.addr_lo[0]) ||
                       ((head.funct3 == 3'b010) && (head.addr_lo != 2'd0)));
    head_fault = head_illegal || head_misaligned;

    head_data = head.result;
    if (head.is_load) begin
      case (head.funct3)
        3'b000:  head_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
        3'b001:  head_data = {{(XLEN-16){ld_half[15]}}, ld_half};
        3'b100:  head_data = {{(XLEN-8){1'b0}}, ld_byte};
        3'b101:  head_data = {{(XLEN-16){1'b0}}, ld_half};
        default: head_data = head.load_data;
      endcase
    end
  end

  assign o_fwd_valid = (count_q != 2'd0) && head.reg_write && (head.rd != '0) && !head_fault;
  assign o_fwd_rd    = head.rd;
  assign o_fwd_data  = head_data;

  // Slot 0 is always the head; a pop shifts slot 1 down before any push lands.
  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    if (pop) begin
      ent_d[0] = ent_q[1];
    end
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        ent_d[0] = in_ent;
      end else begin
        ent_d[1] = in_ent;
      end
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    ready_d = (count_d != 2'd2);

    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    load_fault_d = 1'b0;
    if (pop) begin
      rf_we_d      = head.reg_write && (head.rd != '0) && !head_fault;
      rf_waddr_d   = head.rd;
      rf_wdata_d   = head_data;
      load_fault_d = head_fault;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ent_q[0]     <= '0;
      ent_q[1]     <= '0;
      count_q      <= 2'd0;
      ready_q      <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      load_fault_q <= 1'b0;
    end else begin
      ent_q[0]     <= ent_d[0];
      ent_q[1]     <= ent_d[1];
      count_q      <= count_d;
      ready_q      <= ready_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      load_fault_q <= load_fault_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_rf_we      = rf_we_q;
  assign o_rf_waddr   = rf_waddr_q;
  assign o_rf_wdata   = rf_wdata_q;
  assign o_load_fault = load_fault_q;

`ifdef RAPID_WB_RETIRE_CNT_EN
  logic [63:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q + (pop ? 64'd1 : 64'd0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      retired_q <= 64'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign o_retired = retired_q;
`else
  assign o_retired = 64'd0;
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final RAPID pipeline stage, directly downstream of the memory stage. Accepts completed memory-stage results through a valid/ready handshake into a 2-entry skid buffer, then sign- or zero-extends load data and aligns it by byte offset. Drives the register-file write port, one retirement per cycle. Also exposes the oldest pending result for forwarding and flags misaligned or illegal loads.

## Interface
Parameters:
- XLEN, rapid_pkg::XLEN (32): datapath width; only 32 supported.
- REG_AW, 5: register index width.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_valid  in  1  memory stage has a completed result (its done).
- o_ready  out  1  buffer can accept; registered, high iff count < 2.
- i_rd  in  REG_AW  destination register.
- i_reg_write  in  1  instruction writes rd.
- i_is_load  in  1  select load data instead of i_result.
- i_funct3  in  3  load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- i_addr_lo  in  2  load byte offset.
- i_result  in  XLEN  ALU/address result.
- i_load_data  in  XLEN  raw aligned word from d-cache.
- i_hold  in  1  stall retirement (debug/halt).
- o_rf_we  out  1  register-file write enable.
- o_rf_waddr  out  REG_AW  write address.
- o_rf_wdata  out  XLEN  write data.
- o_fwd_valid  out  1  head entry valid with reg_write and rd≠0.
- o_fwd_rd  out  REG_AW  head entry rd.
- o_fwd_data  out  XLEN  head entry formatted data.
- o_load_fault  out  1  one-cycle pulse: misaligned or illegal-funct3 load retired.
- o_retired  out  64  retired-instruction count.

## Operation
- Push: i_valid && o_ready at an edge stores {rd, reg_write, is_load, funct3, addr_lo, result, load_data} at the tail.
- Pop: count > 0 && !i_hold at an edge removes the head. On pop, o_rf_* register the formatted head. Otherwise o_rf_we = 0.
- Push and pop in the same edge are legal at count 1. Count stays 1 and data flows through the two entries in order.
- At count 2, o_ready = 0, so a push cannot occur. At count 0, a pop cannot occur.
- Formatting, combinational on the head entry:
  - Non-load: i_result.
  - LB/LBU: byte at addr_lo, sign- or zero-extended.
  - LH/LHU: halfword at addr_lo[1]×16, sign- or zero-extended.
  - LW: full word.
- Fault rules:
  - Misaligned if LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0.
  - Illegal if funct3 is 011, 110 or 111 on a load.
  - A faulting entry retires with o_rf_we = 0 and o_load_fault = 1.
- Writes to rd = 0 are suppressed (o_rf_we = 0). The entry still retires.
- o_fwd_* are combinational from the head entry. o_fwd_valid = 0 when the buffer is empty or the head is a faulting load.
- Reset values: count 0, o_ready 0 during reset (1 from the first cycle after release), o_rf_we 0, o_rf_waddr 0, o_rf_wdata 0, o_load_fault 0, o_retired 0.
- Reset asserted mid-operation discards both entries. No write occurs at the reset edge.

## Timing
- Latency: an entry accepted at edge N is popped at edge N+1 if i_hold is low. o_rf_we is high in the cycle after N+1.
- Throughput: one retirement per cycle at steady state.
- i_hold stalls pop only. Pushes continue until count = 2.
- o_ready is registered from the next-state count. It deasserts in the cycle after the push that fills the buffer.
- o_retired increments by 1 on every pop, including suppressed and faulting entries. It wraps modulo 2^64.

## Configuration
- RAPID_WB_RETIRE_CNT_EN defined: 64-bit o_retired counter is implemented as above.
- Not defined: counter logic is removed and o_retired is tied to 0.

## Test plan
- Non-load: rd=5, result=0x1234_5678, reg_write=1 -> o_rf_we=1, waddr=5, wdata=0x1234_5678 two cycles after accept; o_retired=1.
- Loads: load_data=0x80FF_7F01. LB offset 3 -> 0xFFFF_FF80. LBU offset 2 -> 0x0000_00FF. LH offset 2 -> 0xFFFF_80FF. LHU offset 0 -> 0x0000_7F01.
- Faults: LW offset 2, and LH funct3=001 offset 1 -> o_rf_we=0, o_load_fault pulses once per entry, o_retired still increments.
- Hold and backpressure: i_hold=1 with 3 back-to-back valid results.
  - Required: o_ready=0 after 2 accepts; third result held upstream.
  - After releasing hold: three writes on consecutive cycles, in order.
- rd=0 with reg_write=1 -> o_rf_we=0, o_fwd_valid=0, o_retired increments.
- i_reset_n=0 asserted with 2 entries buffered -> no write, count 0, o_retired 0. After release, o_ready=1 on the next cycle.
